vga_sync_decoder: RTL

- Receive end of the VGA timing path: samples active-low H_sync/V_sync on the pixel clock and recovers column/row coordinates, display enable and a frame-start strobe.
- Checks line and frame lengths against the 640x480 timing, and declares lock after consecutive good frames.
- Sits downstream of the sync generators (H and V) and feeds the pixel and game-logic consumers with coordinates.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_edge_det.sv | 24 ++
 rtl/vga_sync_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing defaults, decoder state encoding and counter helpers.
package vga_timing_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_H_START = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_START = DEF_V_SYNC + DEF_V_BP;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

  // Position/line counters stick at CNT_MAX so a lost sync never wraps into the visible area.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// One-bit sample register with a falling-edge pulse; the register only advances when en is high.
module vga_edge_det #(
  parameter logic RESET_VAL = 1'b1
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

  assign fall = en & q & ~d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, display enable and frame strobes from incoming H/V sync,
// and tracks lock by checking line and frame lengths.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int LOCK_FRAMES = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       H_sync,
  input  logic       V_sync,
  output logic [9:0] col_count,
  output logic [9:0] row_count,
  output logic       de,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
  localparam logic [9:0]  H_FIRST   = 10'(H_START);
  localparam logic [9:0]  H_LAST    = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST   = 10'(V_START);
  localparam logic [9:0]  V_LAST    = 10'(V_START + V_ACTIVE - 1);

  localparam int           GW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

  sync_state_t state;
  logic [GW-1:0] good;
  logic [9:0]    hcnt, vcnt;
  logic          first_h, acc_bad;

  logic          h_edge, v_edge;
  logic [9:0]    p_now, v_now;
  logic [10:0]   hlen, vlen;
  logic          line_bad, sat_hit, frame_bad, bad_now, frame_ok;
  logic          vis, stay_locked;

  vga_edge_det #(.RESET_VAL(1'b1)) u_h_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .d    (H_sync),
    .fall (h_edge)
  );

  // V_sync is only meaningful at line boundaries, so its sample advances on H edges.
  vga_edge_det #(.RESET_VAL(1'b1)) u_v_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (h_edge),
    .d    (V_sync),
    .fall (v_edge)
  );

  always_comb begin
    p_now = h_edge ? 10'd0 : sat_inc(hcnt);
    v_now = v_edge ? 10'd0 : (h_edge ? sat_inc(vcnt) : vcnt);
    hlen  = {1'b0, hcnt} + 11'd1;
    vlen  = {1'b0, vcnt} + 11'd1;

    line_bad  = h_edge && !first_h && (hlen != H_TOTAL_L);
    sat_hit   = !h_edge && (hcnt == CNT_MAX - 10'd1);
    frame_bad = v_edge && (vlen != V_TOTAL_L);
    bad_now   = line_bad | sat_hit | frame_bad;
    frame_ok  = !(acc_bad | bad_now);

    vis = (p_now >= H_FIRST) && (p_now <= H_LAST) &&
          (v_now >= V_FIRST) && (v_now <= V_LAST);

    // Lock status for the cycle being registered: drives locked, de and the coordinates together.
    stay_locked = ((state == LOCKED) && !bad_now) ||
                  ((state == MEASURE) && v_edge && frame_ok && (good == LOCK_N - GW'(1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEARCH;
      good        <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      first_h     <= 1'b1;
      acc_bad     <= 1'b0;
      col_count   <= '0;
      row_count   <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      hcnt        <= p_now;
      vcnt        <= v_now;
      frame_start <= v_edge;
      sync_err    <= 1'b0;
      locked      <= stay_locked;
      de          <= stay_locked && vis;
      col_count   <= (stay_locked && vis) ? p_now - H_FIRST : 10'd0;
      row_count   <= (stay_locked && vis) ? v_now - V_FIRST : 10'd0;
      if (h_edge) first_h <= 1'b0;

      case (state)
        SEARCH: begin
          if (v_edge) begin
            state   <= MEASURE;
            good    <= '0;
            acc_bad <= 1'b0;
          end
        end
        MEASURE: begin
          if (v_edge) begin
            acc_bad <= 1'b0;
            if (!frame_ok) begin
              good <= '0;
            end else if (good == LOCK_N - GW'(1)) begin
              good  <= LOCK_N;
              state <= LOCKED;
            end else begin
              good <= good + GW'(1);
            end
          end else if (bad_now) begin
            acc_bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (bad_now) begin
            state    <= SEARCH;
            sync_err <= 1'b1;
            first_h  <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
